// File: rtl/instr_register_gen_if.sv
// rtl/instr_register_gen_if.sv - stimulus/checker bundle for the instruction register
interface instr_register_gen_if #(
    parameter int DEPTH = 32,
    parameter int OPW   = 32,
    parameter int OPCW  = 4
);
    localparam int AW = $clog2(DEPTH);

    logic                     load_en;
    logic [OPCW-1:0]          opcode;
    logic [OPW-1:0]           operand_a;
    logic [OPW-1:0]           operand_b;
    logic [AW-1:0]            write_pointer;
    logic [AW-1:0]            read_pointer;
    logic [OPCW+4*OPW-1:0]    instruction_word;
    logic                     rd_valid;
    logic                     rd_err;

    modport master (
        output load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        input  instruction_word, rd_valid, rd_err
    );

    modport slave (
        input  load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        output instruction_word, rd_valid, rd_err
    );
endinterface

// File: rtl/instr_register_gen.sv
// rtl/instr_register_gen.sv - instruction register storing ops with a precomputed signed result
// Optional feature macro: INSTR_REG_DIV_EN (adds DIV/MOD; otherwise opcodes 6/7 are unsupported).
module instr_register_gen #(
    parameter int DEPTH = 32,
    parameter int OPW   = 32,
    parameter int OPCW  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_register_gen_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 2 * OPW;
    localparam int WW = OPCW + 4 * OPW;

    localparam logic [OPCW-1:0] OP_ZERO  = OPCW'(0);
    localparam logic [OPCW-1:0] OP_PASSA = OPCW'(1);
    localparam logic [OPCW-1:0] OP_PASSB = OPCW'(2);
    localparam logic [OPCW-1:0] OP_ADD   = OPCW'(3);
    localparam logic [OPCW-1:0] OP_SUB   = OPCW'(4);
    localparam logic [OPCW-1:0] OP_MULT  = OPCW'(5);
`ifdef INSTR_REG_DIV_EN
    localparam logic [OPCW-1:0] OP_DIV   = OPCW'(6);
    localparam logic [OPCW-1:0] OP_MOD   = OPCW'(7);
`endif

    logic [WW-1:0]  word_q [DEPTH];
    logic [WW-1:0]  word_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] err_q, err_d;

    logic [WW-1:0]  instruction_word_q, instruction_word_d;
    logic           rd_valid_q, rd_valid_d;
    logic           rd_err_q, rd_err_d;

    logic signed [RW-1:0] a_x, b_x, result;
    logic                 op_err;

    // Operands are widened to the result width first so ADD/SUB/MULT/DIV cannot overflow,
    // including min / -1 which lands on +2^(OPW-1).
    always_comb begin
        a_x    = {{OPW{bus.operand_a[OPW-1]}}, bus.operand_a};
        b_x    = {{OPW{bus.operand_b[OPW-1]}}, bus.operand_b};
        result = '0;
        op_err = 1'b0;
        case (bus.opcode)
            OP_ZERO:  result = '0;
            OP_PASSA: result = a_x;
            OP_PASSB: result = b_x;
            OP_ADD:   result = a_x + b_x;
            OP_SUB:   result = a_x - b_x;
            OP_MULT:  result = a_x * b_x;
`ifdef INSTR_REG_DIV_EN
            OP_DIV, OP_MOD: begin
                if (bus.operand_b == '0) begin
                    op_err = 1'b1;
                end else if (bus.opcode == OP_DIV) begin
                    result = a_x / b_x;
                end else begin
                    result = a_x % b_x;
                end
            end
`endif
            default:  op_err = 1'b1;
        endcase
    end

    // Decoding by equality against each entry makes out-of-range pointers hit nothing.
    always_comb begin
        word_d             = word_q;
        vld_d              = vld_q;
        err_d              = err_q;
        instruction_word_d = '0;
        rd_valid_d         = 1'b0;
        rd_err_d           = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.read_pointer == AW'(i)) begin
                instruction_word_d = word_q[i];
                rd_valid_d         = vld_q[i];
                rd_err_d           = err_q[i];
            end
            if (bus.load_en && (bus.write_pointer == AW'(i))) begin
                word_d[i] = {bus.opcode, bus.operand_a, bus.operand_b, result};
                vld_d[i]  = 1'b1;
                err_d[i]  = op_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
            end
            vld_q              <= '0;
            err_q              <= '0;
            instruction_word_q <= '0;
            rd_valid_q         <= 1'b0;
            rd_err_q           <= 1'b0;
        end else begin
            word_q             <= word_d;
            vld_q              <= vld_d;
            err_q              <= err_d;
            instruction_word_q <= instruction_word_d;
            rd_valid_q         <= rd_valid_d;
            rd_err_q           <= rd_err_d;
        end
    end

    assign bus.instruction_word = instruction_word_q;
    assign bus.rd_valid         = rd_valid_q;
    assign bus.rd_err           = rd_err_q;
endmodule

// File: tb/tb_instr_register_gen.sv
// tb/tb_instr_register_gen.sv - random + directed bench for instr_register_gen (DEPTH 32 and 20)
module tb_instr_register_gen;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_en;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  wp, rp;
    bit          chk_en = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    instr_register_gen_if #(.DEPTH(32), .OPW(32), .OPCW(4)) ir_a ();
    instr_register_gen_if #(.DEPTH(20), .OPW(32), .OPCW(4)) ir_b ();

    assign ir_a.load_en = load_en;  assign ir_b.load_en = load_en;
    assign ir_a.opcode = op;        assign ir_b.opcode = op;
    assign ir_a.operand_a = a;      assign ir_b.operand_a = a;
    assign ir_a.operand_b = b;      assign ir_b.operand_b = b;
    assign ir_a.write_pointer = wp; assign ir_b.write_pointer = wp;
    assign ir_a.read_pointer = rp;  assign ir_b.read_pointer = rp;

    instr_register_gen #(.DEPTH(32), .OPW(32), .OPCW(4)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ir_a));
    instr_register_gen #(.DEPTH(20), .OPW(32), .OPCW(4)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ir_b));

    // Reference: 64-bit integer arithmetic on the sign-extended operands.
    function automatic logic [132:0] model_entry(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sa, sb, r;
        bit     e;
        sa = longint'(signed'(x));
        sb = longint'(signed'(y));
        r  = 0;
        e  = 1'b0;
        case (o)
            4'd0: r = 0;
            4'd1: r = sa;
            4'd2: r = sb;
            4'd3: r = sa + sb;
            4'd4: r = sa - sb;
            4'd5: r = sa * sb;
`ifdef INSTR_REG_DIV_EN
            4'd6: if (sb == 0) e = 1'b1; else r = sa / sb;
            4'd7: if (sb == 0) e = 1'b1; else r = sa % sb;
`endif
            default: e = 1'b1;
        endcase
        if (e) r = 0;
        return {e, o, x, y, r};
    endfunction

    logic [131:0] mw_a [32];
    bit           mv_a [32], me_a [32];
    logic [131:0] mw_b [20];
    bit           mv_b [20], me_b [20];
    logic [131:0] ew_a, ew_b;
    bit           ev_a, ee_a, ev_b, ee_b;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin mw_a[i] <= '0; mv_a[i] <= 1'b0; me_a[i] <= 1'b0; end
            for (int i = 0; i < 20; i++) begin mw_b[i] <= '0; mv_b[i] <= 1'b0; me_b[i] <= 1'b0; end
            ew_a <= '0; ev_a <= 1'b0; ee_a <= 1'b0;
            ew_b <= '0; ev_b <= 1'b0; ee_b <= 1'b0;
        end else begin
            ew_a <= mw_a[rp]; ev_a <= mv_a[rp]; ee_a <= me_a[rp];
            if (rp < 5'd20) begin
                ew_b <= mw_b[rp]; ev_b <= mv_b[rp]; ee_b <= me_b[rp];
            end else begin
                ew_b <= '0; ev_b <= 1'b0; ee_b <= 1'b0;
            end
            if (load_en) begin
                mw_a[wp] <= model_entry(op, a, b)[131:0];
                mv_a[wp] <= 1'b1;
                me_a[wp] <= model_entry(op, a, b)[132];
                if (wp < 5'd20) begin
                    mw_b[wp] <= model_entry(op, a, b)[131:0];
                    mv_b[wp] <= 1'b1;
                    me_b[wp] <= model_entry(op, a, b)[132];
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [131:0] gw, input logic gv, input logic ge,
                       input logic [131:0] xw, input logic xv, input logic xe);
        vectors++;
        if (gw !== xw || gv !== xv || ge !== xe) begin
            miscompares++;
            $display("FAIL %s @%0t: got word=%h v=%b e=%b, want word=%h v=%b e=%b",
                     nm, $time, gw, gv, ge, xw, xv, xe);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_a", ir_a.instruction_word, ir_a.rd_valid, ir_a.rd_err, ew_a, ev_a, ee_a);
            cmp("model_b", ir_b.instruction_word, ir_b.rd_valid, ir_b.rd_err, ew_b, ev_b, ee_b);
        end
    end

    task automatic lit(input string nm, input logic [63:0] xr, input logic xv, input logic xe);
        cmp(nm, {68'h0, ir_a.instruction_word[63:0]}, ir_a.rd_valid, ir_a.rd_err, {68'h0, xr}, xv, xe);
    endtask

    task automatic wr(input logic [4:0] idx, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        load_en = 1'b1; wp = idx; op = o; a = x; b = y;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] idx);
        rp = idx;
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset_n = 1'b0; load_en = 1'b0; op = '0; a = '0; b = '0; wp = '0; rp = '0;
        repeat (2) @(negedge clk);
        cmp("reset_a", ir_a.instruction_word, ir_a.rd_valid, ir_a.rd_err, '0, 1'b0, 1'b0);
        cmp("reset_b", ir_b.instruction_word, ir_b.rd_valid, ir_b.rd_err, '0, 1'b0, 1'b0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        for (int i = 0; i < 32; i++) begin
            rd(5'(i));
            cmp("empty", ir_a.instruction_word, ir_a.rd_valid, ir_a.rd_err, '0, 1'b0, 1'b0);
        end

        wr(5'd3, 4'd3, 32'd5, -32'sd7);
        rd(5'd3);
        cmp("add_word", ir_a.instruction_word, ir_a.rd_valid, ir_a.rd_err,
            {4'd3, 32'd5, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b1, 1'b0);

        wr(5'd4, 4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        rd(5'd4);
        lit("mult_max", 64'h3FFF_FFFF_0000_0001, 1'b1, 1'b0);

        wr(5'd5, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        rd(5'd5);
`ifdef INSTR_REG_DIV_EN
        lit("div_min_m1", 64'h0000_0000_8000_0000, 1'b1, 1'b0);
`else
        lit("div_min_m1", 64'h0, 1'b1, 1'b1);
`endif

        wr(5'd6, 4'd6, 32'd9, 32'd0);
        rd(5'd6);
        lit("div_zero", 64'h0, 1'b1, 1'b1);

        wr(5'd7, 4'd12, 32'd1, 32'd2);
        rd(5'd7);
        lit("op12", 64'h0, 1'b1, 1'b1);

        wr(5'd8, 4'd6, 32'd9, 32'd3);
        rd(5'd8);
`ifdef INSTR_REG_DIV_EN
        lit("div_9_3", 64'd3, 1'b1, 1'b0);
`else
        lit("div_9_3", 64'h0, 1'b1, 1'b1);
`endif

        wr(5'd31, 4'd4, 32'd10, 32'd4);
        load_en = 1'b1; wp = 5'd31; op = 4'd1; a = 32'd1; b = 32'd0; rp = 5'd31;
        @(negedge clk);
        load_en = 1'b0;
        lit("coll_old", 64'd6, 1'b1, 1'b0);
        @(negedge clk);
        lit("coll_new", 64'd1, 1'b1, 1'b0);

        wr(5'd25, 4'd3, 32'd100, 32'd1);
        rd(5'd25);
        cmp("oor_b", ir_b.instruction_word, ir_b.rd_valid, ir_b.rd_err, '0, 1'b0, 1'b0);
        lit("oor_a", 64'd101, 1'b1, 1'b0);
        wr(5'd19, 4'd2, 32'd0, 32'hFFFF_FFFD);
        rd(5'd19);
        cmp("edge_b19", {68'h0, ir_b.instruction_word[63:0]}, ir_b.rd_valid, ir_b.rd_err,
            {68'h0, 64'hFFFF_FFFF_FFFF_FFFD}, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) wr(5'(i), 4'd3, 32'(i), 32'd1);
        rp = 5'd2;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        cmp("rst_mid_a", ir_a.instruction_word, ir_a.rd_valid, ir_a.rd_err, '0, 1'b0, 1'b0);
        cmp("rst_mid_b", ir_b.instruction_word, ir_b.rd_valid, ir_b.rd_err, '0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(5'(i));
            cmp("post_rst", ir_a.instruction_word, ir_a.rd_valid, ir_a.rd_err, '0, 1'b0, 1'b0);
        end

        repeat (3000) begin
            load_en = ($urandom_range(0, 3) != 0);
            op      = 4'($urandom_range(0, 15));
            a       = pick();
            b       = pick();
            wp      = 5'($urandom_range(0, 31));
            rp      = 5'($urandom_range(0, 31));
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
